cnn_frame_feeder: RTL
=====================

// Module: cnn_frame_feeder
// PURPOSE
//  Initiator for the 8x8 binary CNN classifier. Takes a valid/ready grayscale pixel stream,
//  thresholds and packs one 64-pixel frame, issues a one-cycle cnn_start and waits for cnn_done.
//  Returns the classification and an error flag on a valid/ready result stream.
// PARAMETERS
//  PIX_W        8    pixel data width
//  THRESH       128  binarize threshold: pixel >= THRESH -> 1
//  TIMEOUT_CYC  32   cycles after cnn_start without a cnn_done rise before a timeout error
//  ID_W         8    frame id width, wraps
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  pix_valid     in   1       pixel beat valid
//  pix_ready     out  1       feeder accepts a pixel beat
//  pix_data      in   PIX_W   grayscale pixel, raster order (row*8+col)
//  pix_last      in   1       end-of-frame marker
//  cnn_image     out  64      packed binary frame; bit k = pixel k
//  cnn_start     out  1       one-cycle start pulse to the classifier
//  cnn_class     in   4       classifier result
//  cnn_done      in   1       classifier done (level; feeder uses its rising edge)
//  res_valid     out  1       result valid
//  res_ready     in   1       result accepted
//  res_class     out  4       class; 4'hF on error
//  res_err       out  1       1 = short frame or timeout
//  res_frame_id  out  ID_W    id of the frame this result belongs to
// BEHAVIOUR
//  Reset: all outputs 0, beat count 0, frame id 0, done_q 0, state COLLECT.
//  States: COLLECT -> START -> WAIT -> RESULT -> COLLECT. An early pix_last goes COLLECT -> RESULT.
//  COLLECT: pix_ready=1. Each beat with pix_valid writes bit[cnt] = (pix_data >= THRESH) and increments cnt.
//   On beat cnt==63, go to START. pix_last on beat 63 is optional and ignored.
//   pix_last on a beat with cnt<63 is a short frame: latch res_err=1, res_class=4'hF, go to RESULT.
//   The CNN is not started for a short frame.
//  START: cnn_start=1 for exactly one cycle. Load the watchdog with TIMEOUT_CYC. Go to WAIT.
//  WAIT: done rise = cnn_done & ~done_q, where done_q is a registered copy of cnn_done.
//   On a done rise, latch cnn_class with res_err=0 and go to RESULT.
//   If the watchdog reaches 0 first, res_err=1 and res_class=4'hF.
//   A stale high cnn_done left from the previous frame is ignored because only the edge counts.
//  RESULT: res_valid=1; payload stable until res_valid & res_ready.
//   On the handshake cycle, res_valid drops, frame id increments (wraps), cnt clears, state goes to COLLECT.
//  pix_ready=0 in every state except COLLECT. No pixel is accepted while a result is pending.
//  cnn_image is held stable from START until the RESULT handshake. It is cleared only by reset.
//  Nominal latency: last pixel accepted -> cnn_start next cycle. res_valid one cycle after the done rise.
//  Reset mid-operation clears everything asynchronously, and cnn_start goes low immediately.
//   A frame in progress is discarded.
// CONFIGURATION
//  FEEDER_STATS_EN defined: adds outputs stat_frames[15:0] and stat_errors[15:0].
//   Both are saturating counters updated on the result handshake; stat_errors counts res_err=1 results.
//  FEEDER_STATS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.
// STRUCTURE
//  Package cnn_feeder_pkg holds:
//   - state encoding (COLLECT, START, WAIT, RESULT)
//   - IMG_PIXELS=64, IMG_DIM=8
//   - CLASS_W=4, CLASS_ERR=4'hF
//  Sub-module cnn_done_watchdog holds the done_q edge detector and the TIMEOUT_CYC down-counter.
//   Interface: load, done_in -> done_rise, expired.
// TESTING
//  1. 64 beats of 8'hFF, class-3 mock CNN with done after 6 cycles.
//     Expect cnn_image=64'hFFFF_FFFF_FFFF_FFFF, one cnn_start pulse, res_class=3, res_err=0, res_frame_id=0.
//  2. Pixel k = 200 for odd k, 10 for even k.
//     Expect cnn_image=64'hAAAA_AAAA_AAAA_AAAA.
//     Also drive pixel value exactly 128 and expect bit=1.
//  3. pix_last on beat 10.
//     Expect no cnn_start, res_err=1, res_class=4'hF, pix_ready=0 until the handshake, next res_frame_id=1.
//  4. Mock CNN holds cnn_done=1 from the prior frame and never pulses it.
//     Expect res_err=1, res_class=4'hF exactly TIMEOUT_CYC cycles after cnn_start.
//  5. res_ready low for 20 cycles.
//     Expect res_valid held, payload stable, pix_ready=0.
//     Then the handshake, after which the next frame is accepted; the id wraps 255->0 after 256 frames.
//  6. rst_n asserted during WAIT.
//     Expect all outputs 0 at once; the next full frame is processed normally with res_frame_id=0.

Source files
------------

// File: rtl/cnn_feeder_pkg.sv
// cnn_feeder_pkg
//   Shared constants and the feeder state encoding for cnn_frame_feeder.
//   No ports. IMG_PIXELS/IMG_DIM describe the 8x8 binary frame, CLASS_ERR is
//   the class code reported on a short frame or a classifier timeout.
package cnn_feeder_pkg;

  localparam int unsigned IMG_DIM    = 8;
  localparam int unsigned IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int unsigned CNT_W      = $clog2(IMG_PIXELS);
  localparam int unsigned CLASS_W    = 4;

  localparam logic [CLASS_W-1:0] CLASS_ERR = 4'hF;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } feeder_state_e;

endpackage

// File: rtl/cnn_done_watchdog.sv
// cnn_done_watchdog
//   Rising-edge detector on the classifier done level plus the timeout
//   down-counter used while the feeder waits for a result.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      reload the counter (asserted in the cnn_start cycle)
//   done_i      classifier done level
//   done_rise_o done_i high this cycle and low the previous cycle
//   expired_o   TIMEOUT_CYC cycles have elapsed since the load cycle
//               without a reload; meaningful only while waiting
// TIMEOUT_CYC must be at least 2.
module cnn_done_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic done_i,
  output logic done_rise_o,
  output logic expired_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic            done_q;
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  // The load cycle itself counts as the first elapsed cycle, so the counter
  // starts at TIMEOUT_CYC-1 and flags expiry on its final decrement. The
  // feeder then leaves its wait state exactly TIMEOUT_CYC cycles after the
  // load cycle.
  always_comb begin
    wd_d = wd_q;
    if (load_i) begin
      wd_d = WD_W'(TIMEOUT_CYC - 1);
    end else if (wd_q != '0) begin
      wd_d = wd_q - WD_W'(1);
    end
  end

  assign expired_o   = (wd_q == WD_W'(1));
  assign done_rise_o = done_i & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      wd_q   <= '0;
    end else begin
      done_q <= done_i;
      wd_q   <= wd_d;
    end
  end

endmodule

// File: rtl/cnn_frame_feeder.sv
// cnn_frame_feeder
//   Collects one 64-pixel grayscale frame from a valid/ready stream,
//   binarizes it (pixel >= THRESH -> 1), starts the 8x8 binary CNN with a
//   one-cycle pulse, waits for the rising edge of its done level and
//   returns class/error/frame-id on a valid/ready result stream.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   pix_valid/pix_ready/pix_data/pix_last  pixel stream, raster order
//   cnn_image                           packed frame, bit k = pixel k
//   cnn_start                           one-cycle classifier start
//   cnn_class, cnn_done                 classifier result and done level
//   res_valid/res_ready                 result handshake
//   res_class, res_err, res_frame_id    result payload (class 4'hF on error)
// Configuration:
//   FEEDER_STATS_EN  adds stat_frames/stat_errors saturating counters.
module cnn_frame_feeder
  import cnn_feeder_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned THRESH      = 128,
  parameter int unsigned TIMEOUT_CYC = 32,
  parameter int unsigned ID_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_last,
  output logic [IMG_PIXELS-1:0] cnn_image,
  output logic                  cnn_start,
  input  logic [CLASS_W-1:0]    cnn_class,
  input  logic                  cnn_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CLASS_W-1:0]    res_class,
  output logic                  res_err,
  output logic [ID_W-1:0]       res_frame_id
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_errors
`endif
);

  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

  feeder_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IMG_PIXELS-1:0] img_q, img_d;
  logic [CLASS_W-1:0]    cls_q, cls_d;
  logic                  err_q, err_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  rdy_q, rdy_d;

  logic wd_load;
  logic done_rise;
  logic expired;
  logic beat;
  logic res_hs;

  cnn_done_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (wd_load),
    .done_i      (cnn_done),
    .done_rise_o (done_rise),
    .expired_o   (expired)
  );

  assign beat   = pix_valid & rdy_q;
  assign res_hs = (state_q == ST_RESULT) & res_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    img_d   = img_q;
    cls_d   = cls_q;
    err_d   = err_q;
    id_d    = id_q;
    wd_load = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (beat) begin
          img_d[cnt_q] = (pix_data >= THRESH_V);
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IMG_PIXELS - 1)) begin
            state_d = ST_START;
          end else if (pix_last) begin
            cls_d   = CLASS_ERR;
            err_d   = 1'b1;
            state_d = ST_RESULT;
          end
        end
      end
      ST_START: begin
        wd_load = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          cls_d   = cnn_class;
          err_d   = 1'b0;
          state_d = ST_RESULT;
        end else if (expired) begin
          cls_d   = CLASS_ERR;
          err_d   = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          id_d    = id_q + ID_W'(1);
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    // Registered ready keeps pix_ready low while in reset even though the
    // reset state is COLLECT.
    rdy_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      img_q   <= '0;
      cls_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      id_q    <= id_d;
      rdy_q   <= rdy_d;
    end
  end

  assign pix_ready    = rdy_q;
  assign cnn_image    = img_q;
  assign cnn_start    = (state_q == ST_START);
  assign res_valid    = (state_q == ST_RESULT);
  assign res_class    = cls_q;
  assign res_err      = err_q;
  assign res_frame_id = id_q;

`ifdef FEEDER_STATS_EN
  logic [15:0] frames_q, errors_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      errors_q <= '0;
    end else if (res_hs) begin
      if (frames_q != '1) begin
        frames_q <= frames_q + 16'd1;
      end
      if (err_q && (errors_q != '1)) begin
        errors_q <= errors_q + 16'd1;
      end
    end
  end

  assign stat_frames = frames_q;
  assign stat_errors = errors_q;
`else
  logic unused_hs;
  assign unused_hs = res_hs;
`endif

endmodule
